// File: rtl/rectangle_scanner_pkg.sv
// rectangle_scanner_pkg: shared command layout, op codes and scanner states
package rectangle_scanner_pkg;
  localparam int POSITION_WIDTH = 12;
  typedef enum logic [1:0] {
    OP_OFF    = 2'b00,
    OP_TOGGLE = 2'b01,
    OP_ON     = 2'b11
  } op_e;
  typedef struct packed {
    op_e                       op;
    logic [POSITION_WIDTH-1:0] start_row;
    logic [POSITION_WIDTH-1:0] start_col;
    logic [POSITION_WIDTH-1:0] end_row;
    logic [POSITION_WIDTH-1:0] end_col;
  } cmd_s;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SCAN, S_DONE} state_e;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two circular buffer; a push while full is taken only alongside a pop
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic do_push, do_pop;
  assign full    = count_q == CW'(DEPTH);
  assign empty   = count_q == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_q];
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop) rd_q <= rd_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/rectangle_scanner.sv
// rectangle_scanner: buffers rectangle commands and emits their cells row-major
module rectangle_scanner #(
  parameter int INSTRUCTION_WIDTH = 50,
  parameter int FIFO_DEPTH        = 4,
  parameter int POSITION_WIDTH    = 12
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         end_of_file,
  input  logic                         normalized_instr_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] normalized_instr_data,
  output logic                         cell_valid,
  input  logic                         cell_ready,
  output logic [1:0]                   cell_op,
  output logic [POSITION_WIDTH-1:0]    cell_row,
  output logic [POSITION_WIDTH-1:0]    cell_col,
  output logic                         cell_last,
  output logic                         scan_done,
  output logic                         overflow
);
  import rectangle_scanner_pkg::*;
  localparam int P = POSITION_WIDTH;
  state_e state_q;
  logic [INSTRUCTION_WIDTH-1:0] fifo_dout, cmd_q;
  logic fifo_full, fifo_empty, push, pop, accept, wrap;
  logic eof_seen_q, cell_valid_q, cell_last_q, scan_done_q, overflow_q;
  logic [1:0] op_q;
  logic [P-1:0] row_q, col_q, row_n, col_n, sr, sc, er, ec;
  assign {sr, sc, er, ec} = cmd_q[4*P-1:0];
  assign pop    = state_q == S_IDLE && !fifo_empty;
  assign push   = normalized_instr_valid && (!fifo_full || pop);
  assign accept = cell_valid_q && cell_ready;
  assign wrap   = col_q == ec;
  assign row_n  = wrap ? row_q + P'(1) : row_q;
  assign col_n  = wrap ? sc : col_q + P'(1);
  sync_fifo #(
    .WIDTH(INSTRUCTION_WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .din  (normalized_instr_data),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );
  assign cell_valid = cell_valid_q;
  assign cell_op    = op_q;
  assign cell_row   = row_q;
  assign cell_col   = col_q;
  assign cell_last  = cell_last_q;
  assign scan_done  = scan_done_q;
  assign overflow   = overflow_q;
  // Commands arriving after DONE are buffered but never scanned, so they count as lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cmd_q        <= '0;
      row_q        <= '0;
      col_q        <= '0;
      op_q         <= '0;
      eof_seen_q   <= 1'b0;
      cell_valid_q <= 1'b0;
      cell_last_q  <= 1'b0;
      scan_done_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      eof_seen_q <= eof_seen_q || end_of_file;
      if (normalized_instr_valid && (!push || state_q == S_DONE)) overflow_q <= 1'b1;
      case (state_q)
        S_IDLE:
          if (pop) begin
            cmd_q   <= fifo_dout;
            state_q <= S_LOAD;
          end else if (eof_seen_q && !normalized_instr_valid) begin
            state_q     <= S_DONE;
            scan_done_q <= 1'b1;
          end
        S_LOAD:
          if (sr <= er && sc <= ec) begin
            row_q        <= sr;
            col_q        <= sc;
            op_q         <= cmd_q[4*P+1:4*P];
            cell_last_q  <= sr == er && sc == ec;
            cell_valid_q <= 1'b1;
            state_q      <= S_SCAN;
          end else begin
            state_q <= S_IDLE;
          end
        S_SCAN:
          if (accept) begin
            if (cell_last_q) begin
              cell_valid_q <= 1'b0;
              cell_last_q  <= 1'b0;
              state_q      <= S_IDLE;
            end else begin
              row_q       <= row_n;
              col_q       <= col_n;
              cell_last_q <= row_n == er && col_n == ec;
            end
          end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rectangle_scanner.sv
// tb_rectangle_scanner: scoreboard-driven checks of cell order, timing, overflow, eof and reset
module tb_rectangle_scanner;
  import rectangle_scanner_pkg::*;
  typedef struct packed {
    logic [1:0]  op;
    logic [11:0] row;
    logic [11:0] col;
    logic        last;
  } cell_t;
  logic clk = 1'b0, reset = 1'b1, end_of_file = 1'b0, valid = 1'b0, cell_ready = 1'b0;
  logic [49:0] data = '0;
  logic cell_valid, cell_last, scan_done, overflow;
  logic [1:0] cell_op;
  logic [11:0] cell_row, cell_col;
  cell_t exp_q[$];
  int vectors = 0, miscompares = 0;
  always #5 clk = ~clk;
  rectangle_scanner dut (
    .clk                   (clk),
    .reset                 (reset),
    .end_of_file           (end_of_file),
    .normalized_instr_valid(valid),
    .normalized_instr_data (data),
    .cell_valid            (cell_valid),
    .cell_ready            (cell_ready),
    .cell_op               (cell_op),
    .cell_row              (cell_row),
    .cell_col              (cell_col),
    .cell_last             (cell_last),
    .scan_done             (scan_done),
    .overflow              (overflow)
  );
  function automatic logic [49:0] mk(input op_e op, input int sr, input int sc, input int er, input int ec);
    cmd_s c;
    c.op = op;
    c.start_row = 12'(sr);
    c.start_col = 12'(sc);
    c.end_row = 12'(er);
    c.end_col = 12'(ec);
    return c;
  endfunction
  task automatic expect_cells(input logic [1:0] op, input int sr, input int sc, input int er, input int ec, input int lim);
    int n = 0;
    cell_t e;
    for (int r = sr; r <= er && n < lim; r++)
      for (int c = sc; c <= ec && n < lim; c++) begin
        e.op = op;
        e.row = 12'(r);
        e.col = 12'(c);
        e.last = (r == er) && (c == ec);
        exp_q.push_back(e);
        n++;
      end
  endtask
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic strobe(input logic [49:0] cmd);
    data = cmd;
    valid = 1'b1;
    tick(1);
    valid = 1'b0;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    exp_q.delete();
  endtask
  task automatic drain(input int budget);
    int n = 0;
    cell_t got, exp;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
      if (cell_valid && cell_ready) begin
        got = {cell_op, cell_row, cell_col, cell_last};
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("FAIL cell: got op=%b r=%0d c=%0d last=%b, required op=%b r=%0d c=%0d last=%b",
                   got.op, got.row, got.col, got.last, exp.op, exp.row, exp.col, exp.last);
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d cells still pending, required 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    reset = 1'b1;
    data = mk(OP_ON, 0, 0, 0, 0);
    valid = 1'b1;
    tick(2);
    valid = 1'b0;
    reset = 1'b0;
    vectors += 7;
    if (cell_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b required 0", cell_valid); end
    if (cell_last !== 1'b0) begin miscompares++; $display("FAIL reset_last: got %b required 0", cell_last); end
    if (cell_op !== 2'b00) begin miscompares++; $display("FAIL reset_op: got %b required 00", cell_op); end
    if (cell_row !== 12'd0) begin miscompares++; $display("FAIL reset_row: got %0d required 0", cell_row); end
    if (cell_col !== 12'd0) begin miscompares++; $display("FAIL reset_col: got %0d required 0", cell_col); end
    if (scan_done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b required 0", scan_done); end
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b required 0", overflow); end
    begin
      bit seen = 0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (cell_valid) seen = 1;
      end
      vectors++;
      if (seen) begin miscompares++; $display("FAIL reset_ignores_strobe: got cell_valid=1 required 0"); end
    end
    tick(1);
  endtask
  task automatic test_toggle();
    cell_t got, exp;
    logic want;
    do_reset();
    cell_ready = 1'b1;
    expect_cells(OP_TOGGLE, 0, 0, 1, 1, 100);
    strobe(mk(OP_TOGGLE, 0, 0, 1, 1));
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      want = (i >= 2 && i <= 5);
      vectors++;
      if (cell_valid !== want) begin
        miscompares++;
        $display("FAIL toggle_valid[%0d]: got %b required %b", i, cell_valid, want);
      end
      if (want && cell_valid && exp_q.size() != 0) begin
        got = {cell_op, cell_row, cell_col, cell_last};
        exp = exp_q.pop_front();
        vectors++;
        if (got !== exp) begin
          miscompares++;
          $display("FAIL toggle_cell[%0d]: got op=%b r=%0d c=%0d last=%b, required op=%b r=%0d c=%0d last=%b",
                   i, got.op, got.row, got.col, got.last, exp.op, exp.row, exp.col, exp.last);
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin miscompares++; $display("FAIL toggle_count: %0d cells missing, required 0", exp_q.size()); end
    @(posedge clk);
    #1;
  endtask
  task automatic test_hold();
    int n = 0;
    cell_t got;
    do_reset();
    cell_ready = 1'b0;
    expect_cells(OP_ON, 5, 7, 5, 7, 100);
    strobe(mk(OP_ON, 5, 7, 5, 7));
    while (!cell_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!cell_valid) begin miscompares++; $display("FAIL hold_start: got cell_valid=0 required 1"); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      got = {cell_op, cell_row, cell_col, cell_last};
      vectors++;
      if (!cell_valid || got !== exp_q[0]) begin
        miscompares++;
        $display("FAIL hold_stable[%0d]: got v=%b op=%b r=%0d c=%0d last=%b, required v=1 op=11 r=5 c=7 last=1",
                 i, cell_valid, got.op, got.row, got.col, got.last);
      end
    end
    @(posedge clk);
    #1;
    cell_ready = 1'b1;
    drain(10);
    tick(1);
    vectors++;
    if (cell_valid !== 1'b0) begin miscompares++; $display("FAIL hold_single: got cell_valid=%b required 0", cell_valid); end
  endtask
  task automatic test_overflow();
    op_e ops [6];
    ops[0] = OP_OFF; ops[1] = OP_TOGGLE; ops[2] = OP_ON;
    ops[3] = OP_OFF; ops[4] = OP_TOGGLE; ops[5] = OP_ON;
    do_reset();
    cell_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        vectors++;
        if (overflow !== 1'b0) begin miscompares++; $display("FAIL overflow_early: got %b required 0", overflow); end
      end
      data = mk(ops[i], 0, 0, 9, 9);
      valid = 1'b1;
      if (i < 5) expect_cells(ops[i], 0, 0, 9, 9, 100);
      tick(1);
    end
    valid = 1'b0;
    tick(1);
    vectors++;
    if (overflow !== 1'b1) begin miscompares++; $display("FAIL overflow_set: got %b required 1", overflow); end
    cell_ready = 1'b1;
    drain(1000);
    tick(4);
    vectors++;
    if (cell_valid !== 1'b0) begin miscompares++; $display("FAIL overflow_dropped: got cell_valid=%b required 0", cell_valid); end
  endtask
  task automatic test_inverted();
    bit seen = 0;
    do_reset();
    cell_ready = 1'b1;
    strobe(mk(OP_TOGGLE, 3, 3, 2, 2));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (cell_valid) seen = 1;
    end
    vectors++;
    if (seen) begin miscompares++; $display("FAIL inverted_cells: got cell_valid=1 required 0"); end
    @(posedge clk);
    #1;
    expect_cells(OP_ON, 1, 2, 1, 3, 100);
    strobe(mk(OP_ON, 1, 2, 1, 3));
    drain(20);
  endtask
  task automatic test_eof();
    int n = 0;
    do_reset();
    cell_ready = 1'b1;
    expect_cells(OP_TOGGLE, 0, 0, 0, 2, 100);
    strobe(mk(OP_TOGGLE, 0, 0, 0, 2));
    expect_cells(OP_OFF, 2, 0, 3, 1, 100);
    strobe(mk(OP_OFF, 2, 0, 3, 1));
    end_of_file = 1'b1;
    tick(1);
    end_of_file = 1'b0;
    drain(50);
    vectors++;
    if (scan_done !== 1'b0) begin miscompares++; $display("FAIL eof_early: got scan_done=%b required 0", scan_done); end
    while (!scan_done && n < 10) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (scan_done !== 1'b1) begin miscompares++; $display("FAIL eof_done: got scan_done=%b required 1", scan_done); end
    vectors++;
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL eof_overflow: got %b required 0", overflow); end
    @(posedge clk);
    #1;
    strobe(mk(OP_ON, 0, 0, 0, 0));
    tick(4);
    vectors += 3;
    if (overflow !== 1'b1) begin miscompares++; $display("FAIL done_push_overflow: got %b required 1", overflow); end
    if (scan_done !== 1'b1) begin miscompares++; $display("FAIL done_sticky: got %b required 1", scan_done); end
    if (cell_valid !== 1'b0) begin miscompares++; $display("FAIL done_no_scan: got cell_valid=%b required 0", cell_valid); end
  endtask
  task automatic test_reset_mid();
    bit seen = 0;
    do_reset();
    cell_ready = 1'b1;
    expect_cells(OP_TOGGLE, 0, 0, 999, 999, 20);
    strobe(mk(OP_TOGGLE, 0, 0, 999, 999));
    strobe(mk(OP_ON, 0, 0, 0, 0));
    drain(40);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    vectors += 7;
    if (cell_valid !== 1'b0) begin miscompares++; $display("FAIL abort_valid: got %b required 0", cell_valid); end
    if (cell_last !== 1'b0) begin miscompares++; $display("FAIL abort_last: got %b required 0", cell_last); end
    if (cell_op !== 2'b00) begin miscompares++; $display("FAIL abort_op: got %b required 00", cell_op); end
    if (cell_row !== 12'd0) begin miscompares++; $display("FAIL abort_row: got %0d required 0", cell_row); end
    if (cell_col !== 12'd0) begin miscompares++; $display("FAIL abort_col: got %0d required 0", cell_col); end
    if (scan_done !== 1'b0) begin miscompares++; $display("FAIL abort_done: got %b required 0", scan_done); end
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL abort_overflow: got %b required 0", overflow); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cell_valid) seen = 1;
    end
    vectors++;
    if (seen) begin miscompares++; $display("FAIL abort_fifo_flushed: got cell_valid=1 required 0"); end
    @(posedge clk);
    #1;
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end
  initial begin
    test_reset();
    test_toggle();
    test_hold();
    test_overflow();
    test_inverted();
    test_eof();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
